// File: rtl/apb_ctrl_pkg.sv
// Shared types for the two-requester APB master: FSM states, requester count
// and the latched command record.
package apb_ctrl_pkg;

  localparam int unsigned NUM_REQ        = 2;
  localparam int unsigned CMD_ADDR_WIDTH = 8;
  localparam int unsigned CMD_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                      write;
    logic [CMD_ADDR_WIDTH-1:0] addr;
    logic [CMD_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant from the request vector, and a
// priority pointer that flips to the loser only when the grant is accepted.
import apb_ctrl_pkg::*;

module apb_rr_arbiter (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic               prio
);

  logic prio_q, prio_d;

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // After granting requester 0 the other one gets priority, and vice versa.
  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

  assign prio = prio_q;

endmodule

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin command accept, SETUP/ACCESS
// sequencing with PREADY wait states, wait-state timeout and routed responses.
import apb_ctrl_pkg::*;

module apb_master_arb #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSELx,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // The command record has fixed field widths, so the bus widths must match it.
  if (ADDR_WIDTH != CMD_ADDR_WIDTH || DATA_WIDTH != CMD_DATA_WIDTH) begin : g_width_check
    $error("apb_master_arb: ADDR_WIDTH/DATA_WIDTH must match apb_cmd_t field widths");
  end

  apb_state_e              state_q, state_d;
  apb_cmd_t                cmd_q, cmd_d;
  logic                    gnt_q, gnt_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]      grant;
  logic                    accept;
  logic                    arb_prio;
  logic                    arb_prio_unused;

  apb_rr_arbiter u_arb (
    .clk    (PCLK),
    .rst    (PRESET),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant),
    .prio   (arb_prio)
  );

  assign arb_prio_unused = arb_prio;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    gnt_d       = gnt_q;
    wait_d      = wait_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    accept      = 1'b0;
    req_ready   = '0;

    unique case (state_q)
      IDLE: begin
        if ((|req_valid) && !PRESET) begin
          accept      = 1'b1;
          req_ready   = grant;
          gnt_d       = grant[1];
          cmd_d.write = grant[1] ? req_write[1] : req_write[0];
          cmd_d.addr  = grant[1] ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                 : req_addr[0 +: ADDR_WIDTH];
          cmd_d.wdata = grant[1] ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                 : req_wdata[0 +: DATA_WIDTH];
          wait_d      = '0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          state_d     = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          rsp_rdata_d = cmd_q.write ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          state_d     = IDLE;
        end else if (TIMEOUT != 0 && (32'(wait_q) + 32'd1) == TIMEOUT) begin
          // This low-PREADY cycle is the TIMEOUT-th one: abort now.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else if (32'(wait_q) < TIMEOUT) begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      gnt_q       <= 1'b0;
      wait_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      gnt_q       <= gnt_d;
      wait_q      <= wait_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = cmd_q.write;
  assign PADDR     = cmd_q.addr;
  assign PWDATA    = cmd_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: single write, waited read, contention,
// slave error, timeout abort and reset during ACCESS.
module tb_apb_master_arb;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  apb_master_arb #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"},   64'(PSELx),     64'd0);
    chk({tag, "_pen"},    64'(PENABLE),   64'd0);
    chk({tag, "_pwrite"}, 64'(PWRITE),    64'd0);
    chk({tag, "_paddr"},  64'(PADDR),     64'd0);
    chk({tag, "_pwdata"}, 64'(PWDATA),    64'd0);
    chk({tag, "_rspv"},   64'(rsp_valid), 64'd0);
    chk({tag, "_rdata"},  64'(rsp_rdata), 64'd0);
    chk({tag, "_err"},    64'(rsp_err),   64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    tick; tick;
    chk_all_zero("reset");
    chk("reset_ready", 64'(req_ready), 64'd0);
    PRESET = 1'b0;
    tick;

    // Single zero-wait write from requester 0
    req_write = 2'b01; req_addr = {8'h00, 8'h10}; req_wdata = {32'h0, 32'hDEADBEEF};
    PREADY = 1'b1; req_valid = 2'b01; #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    tick; req_valid = '0; #1;
    chk("t1_setup_psel", 64'(PSELx), 64'd1);
    chk("t1_setup_pen",  64'(PENABLE), 64'd0);
    chk("t1_paddr",      64'(PADDR), 64'h10);
    chk("t1_pwrite",     64'(PWRITE), 64'd1);
    chk("t1_pwdata",     64'(PWDATA), 64'hDEADBEEF);
    chk("t1_ready_busy", 64'(req_ready), 64'd0);
    tick;
    chk("t1_access_pen",  64'(PENABLE), 64'd1);
    chk("t1_access_psel", 64'(PSELx), 64'd1);
    tick;
    chk("t1_rspv",  64'(rsp_valid), 64'h1);
    chk("t1_err",   64'(rsp_err), 64'd0);
    chk("t1_rdata", 64'(rsp_rdata), 64'd0);
    chk("t1_psel_off", 64'(PSELx), 64'd0);
    tick;
    chk("t1_rspv_pulse", 64'(rsp_valid), 64'd0);

    // Read from requester 1 with 3 wait states; PSLVERR ignored while PREADY low
    req_write = 2'b00; req_addr = {8'h24, 8'h00}; PREADY = 1'b0; PSLVERR = 1'b1;
    req_valid = 2'b10; #1;
    chk("t2_ready", 64'(req_ready), 64'h2);
    tick; req_valid = '0; #1;
    chk("t2_paddr_setup", 64'(PADDR), 64'h24);
    chk("t2_pwrite", 64'(PWRITE), 64'd0);
    tick;
    for (int w = 0; w < 3; w++) begin
      chk("t2_wait_pen",   64'(PENABLE), 64'd1);
      chk("t2_wait_paddr", 64'(PADDR), 64'h24);
      chk("t2_wait_rspv",  64'(rsp_valid), 64'd0);
      tick;
    end
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h12345678; #1;
    chk("t2_last_paddr", 64'(PADDR), 64'h24);
    tick;
    chk("t2_rspv",  64'(rsp_valid), 64'h2);
    chk("t2_rdata", 64'(rsp_rdata), 64'h12345678);
    chk("t2_err",   64'(rsp_err), 64'd0);
    PRDATA = '0;

    // Contention: both held valid, grant alternates 0,1,0,1
    req_write = 2'b11; req_addr = {8'h41, 8'h40}; req_wdata = {32'hB1B1B1B1, 32'hA0A0A0A0};
    PREADY = 1'b1; req_valid = 2'b11; #1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_oh;
      exp_oh = (i % 2 == 1) ? 2'b10 : 2'b01;
      chk("t3_ready", 64'(req_ready), 64'(exp_oh));
      tick;
      chk("t3_paddr",  64'(PADDR), (i % 2 == 1) ? 64'h41 : 64'h40);
      chk("t3_pwdata", 64'(PWDATA), (i % 2 == 1) ? 64'hB1B1B1B1 : 64'hA0A0A0A0);
      tick; tick;
      chk("t3_rspv", 64'(rsp_valid), 64'(exp_oh));
      if (i == 3) req_valid = '0;
    end
    tick;

    // Slave error on a read: error flagged, sampled PRDATA returned, then held
    req_write = 2'b00; req_addr = {8'h00, 8'h30}; PREADY = 1'b1; PSLVERR = 1'b1;
    PRDATA = 32'hCAFEF00D; req_valid = 2'b01; #1;
    chk("t4_ready", 64'(req_ready), 64'h1);
    tick; req_valid = '0;
    tick; tick;
    chk("t4_rspv",  64'(rsp_valid), 64'h1);
    chk("t4_err",   64'(rsp_err), 64'd1);
    chk("t4_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
    PSLVERR = 1'b0; PRDATA = '0;
    tick;
    chk("t4_rspv_off",  64'(rsp_valid), 64'd0);
    chk("t4_err_hold",  64'(rsp_err), 64'd1);
    chk("t4_rdata_hold", 64'(rsp_rdata), 64'hCAFEF00D);

    // Timeout: PREADY low for 16 ACCESS cycles aborts the read
    req_write = 2'b00; req_addr = {8'h50, 8'h00}; PREADY = 1'b0; PRDATA = 32'h5555AAAA;
    req_valid = 2'b10; #1;
    chk("t5_ready", 64'(req_ready), 64'h2);
    tick; req_valid = '0;
    tick;
    for (int c = 0; c < 15; c++) tick;
    chk("t5_last_psel", 64'(PSELx), 64'd1);
    chk("t5_last_pen",  64'(PENABLE), 64'd1);
    chk("t5_last_rspv", 64'(rsp_valid), 64'd0);
    tick;
    chk("t5_psel",  64'(PSELx), 64'd0);
    chk("t5_pen",   64'(PENABLE), 64'd0);
    chk("t5_rspv",  64'(rsp_valid), 64'h2);
    chk("t5_err",   64'(rsp_err), 64'd1);
    chk("t5_rdata", 64'(rsp_rdata), 64'd0);
    req_write = 2'b01; req_addr = {8'h00, 8'h60}; req_wdata = {32'h0, 32'h00000060};
    req_valid = 2'b01; #1;
    chk("t5_idle_ready", 64'(req_ready), 64'h1);
    tick; req_valid = '0; PREADY = 1'b1;
    tick; tick;
    chk("t5_next_rspv", 64'(rsp_valid), 64'h1);
    chk("t5_next_err",  64'(rsp_err), 64'd0);
    PRDATA = '0;

    // Reset during a wait state; pointer must come back to requester 0
    req_write = 2'b00; req_addr = {8'h00, 8'h70}; req_wdata = {32'h0, 32'h77777777};
    PREADY = 1'b0; req_valid = 2'b01; #1;
    chk("t6_ready", 64'(req_ready), 64'h1);
    tick; req_valid = '0;
    tick; tick;
    PRESET = 1'b1;
    tick;
    chk_all_zero("t6_reset");
    PRESET = 1'b0; PREADY = 1'b1;
    tick;
    chk("t6_no_rspv", 64'(rsp_valid), 64'd0);
    req_write = 2'b00; req_addr = {8'h81, 8'h80}; req_valid = 2'b11; #1;
    chk("t6_first_grant", 64'(req_ready), 64'h1);
    tick; req_valid = '0;
    chk("t6_paddr", 64'(PADDR), 64'h80);
    tick; tick;
    chk("t6_rspv", 64'(rsp_valid), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
